axi4_regbank_arbiter: RTL

Round-robin scheduler that shares the single-port AXI4 register bank between the write path (paired AW+W entries) and the read path (AR entries). It accepts one request at a time, performs the address decode and bank access, and returns a B or R response with OKAY/DECERR. It sits between the channel FIFOs and the register bank storage.

---
 rtl/axi4_regbank_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4_regbank_arbiter.sv
// axi4_regbank_arbiter
//
// Round-robin scheduler that shares a single-port register bank between a write
// request path (paired AW+W) and a read request path (AR). It accepts one request
// at a time, decodes the address, drives one bank access cycle and returns a B or
// R response (OKAY / DECERR). Only one transaction is in flight at a time.
//
// Ports:
//   ACLK, ARESET          clock (rising edge), synchronous active-high reset
//   wr_req_*              write request handshake and payload (id/addr/data/strb)
//   rd_req_*              read request handshake and payload (id/addr)
//   bank_*                bank access strobe and payload; bank_rdata returns one
//                         cycle after a read strobe
//   b_*                   write response channel
//   r_*                   read response channel
//   err_count             saturating count of DECERR responses issued
//
// Build option:
//   AXI4_REGBANK_WSTRB_EN  when defined, the captured write strobes are forwarded
//                          to the bank; otherwise every write is a full-word write.

module axi4_regbank_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 15,
  localparam int unsigned IDX_W     = $clog2(DEPTH),
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // Write request
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ID_WIDTH-1:0]   wr_req_id,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic [STRB_W-1:0]     wr_req_strb,
  // Read request
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ID_WIDTH-1:0]   rd_req_id,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  // Register bank
  output logic                  bank_en,
  output logic                  bank_we,
  output logic [IDX_W-1:0]      bank_addr,
  output logic [DATA_WIDTH-1:0] bank_wdata,
  output logic [STRB_W-1:0]     bank_wstrb,
  input  logic [DATA_WIDTH-1:0] bank_rdata,
  // Write response
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  // Read response
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  // Status
  output logic [7:0]            err_count
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] EndAddr = ADDR_WIDTH'(END_ADDR);

  typedef enum logic [2:0] {StIdle, StAccess, StRdWait, StBResp, StRResp} state_e;

  state_e                  state_q;
  logic                    last_wr_q;   // 1: write was granted last, 0: read
  logic                    is_wr_q;
  logic                    in_range_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic                    bank_en_q, bank_we_q;
  logic [IDX_W-1:0]        bank_addr_q;
  logic [DATA_WIDTH-1:0]   bank_wdata_q;
  logic [STRB_W-1:0]       bank_wstrb_q;
  logic                    b_valid_q, r_valid_q;
  logic [ID_WIDTH-1:0]     b_id_q, r_id_q;
  logic [1:0]              b_resp_q, r_resp_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic [7:0]              err_q;

  // Arbitration: a lone requester wins; on a tie the side not granted last wins.
  logic win_wr, win_rd, idle_ok;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [STRB_W-1:0]     req_strb;
  logic lo_ok, hi_ok, req_in_range;

  always_comb begin
    win_wr   = wr_req_valid && (!rd_req_valid || !last_wr_q);
    win_rd   = rd_req_valid && !win_wr;
    idle_ok  = (state_q == StIdle) && !ARESET;
    req_addr = win_wr ? wr_req_addr : rd_req_addr;
  end

  assign wr_req_ready = idle_ok && win_wr;
  assign rd_req_ready = idle_ok && win_rd;

  // Skip the lower-bound compare when it is trivially true.
  if (START_ADDR == 0) begin : g_lo_zero
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_ADDR);
    assign lo_ok = (req_addr >= StartAddr);
  end
  assign hi_ok        = (req_addr <= EndAddr);
  assign req_in_range = lo_ok && hi_ok;

`ifdef AXI4_REGBANK_WSTRB_EN
  assign req_strb = wr_req_strb;
`else
  logic unused_strb;
  assign unused_strb = ^wr_req_strb;
  assign req_strb    = '1;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      last_wr_q    <= 1'b0;
      is_wr_q      <= 1'b0;
      in_range_q   <= 1'b0;
      id_q         <= '0;
      bank_en_q    <= 1'b0;
      bank_we_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      bank_wstrb_q <= '0;
      b_valid_q    <= 1'b0;
      b_id_q       <= '0;
      b_resp_q     <= '0;
      r_valid_q    <= 1'b0;
      r_id_q       <= '0;
      r_data_q     <= '0;
      r_resp_q     <= '0;
      err_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_wr || win_rd) begin
            is_wr_q      <= win_wr;
            in_range_q   <= req_in_range;
            id_q         <= win_wr ? wr_req_id : rd_req_id;
            last_wr_q    <= win_wr;
            // Bank strobe is registered here so it is high for exactly the access cycle.
            bank_en_q    <= req_in_range;
            bank_we_q    <= win_wr;
            bank_addr_q  <= req_addr[IDX_W-1:0];
            bank_wdata_q <= win_wr ? wr_req_data : '0;
            bank_wstrb_q <= win_wr ? req_strb : '0;
            state_q      <= StAccess;
          end
        end
        StAccess: begin
          bank_en_q <= 1'b0;
          bank_we_q <= 1'b0;
          if (is_wr_q) begin
            b_id_q    <= id_q;
            b_resp_q  <= in_range_q ? RespOkay : RespDecerr;
            b_valid_q <= 1'b1;
            if (!in_range_q && err_q != 8'hFF) err_q <= err_q + 8'd1;
            state_q   <= StBResp;
          end else begin
            state_q   <= StRdWait;
          end
        end
        StRdWait: begin
          r_id_q    <= id_q;
          r_data_q  <= in_range_q ? bank_rdata : '0;
          r_resp_q  <= in_range_q ? RespOkay : RespDecerr;
          r_valid_q <= 1'b1;
          if (!in_range_q && err_q != 8'hFF) err_q <= err_q + 8'd1;
          state_q   <= StRResp;
        end
        StBResp: begin
          if (b_ready) begin
            b_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StRResp: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gating with reset drops a bank write that was captured but not yet committed.
  assign bank_en    = bank_en_q && !ARESET;
  assign bank_we    = bank_we_q && !ARESET;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;
  assign bank_wstrb = bank_wstrb_q;
  assign b_valid    = b_valid_q;
  assign b_id       = b_id_q;
  assign b_resp     = b_resp_q;
  assign r_valid    = r_valid_q;
  assign r_id       = r_id_q;
  assign r_data     = r_data_q;
  assign r_resp     = r_resp_q;
  assign err_count  = err_q;

endmodule
